// File: rtl/mem_bank_ctl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : mem_bank_ctl
// Description : Multi-bank single-ported word memory controller with one write
//               port and two read ports (lo, hi). Banks are interleaved on the
//               low address bits. Reads that lose bank arbitration are held in
//               a small replay buffer and reissued on following cycles. The
//               array is zero-filled by an INIT sweep after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bank_ctl #(
    parameter  int NUM_BANKS  = 4,
    parameter  int DATA_WIDTH = 39,
    parameter  int DEPTH      = 256,
    localparam int BW         = $clog2(NUM_BANKS),
    localparam int RW         = $clog2(DEPTH),
    localparam int AW         = BW + RW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  rd_lo_valid,
    input  logic [AW-1:0]         rd_lo_addr,
    input  logic                  rd_hi_valid,
    input  logic [AW-1:0]         rd_hi_addr,
    input  logic                  wr_valid,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] rd_lo_data,
    output logic [DATA_WIDTH-1:0] rd_hi_data,
    output logic                  rd_lo_dvalid,
    output logic                  rd_hi_dvalid,
    output logic                  init_done
);

    localparam logic [1:0] C_ST_INIT   = 2'd0;
    localparam logic [1:0] C_ST_RUN    = 2'd1;
    localparam logic [1:0] C_ST_REPLAY = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [RW-1:0]         r_init_row;
    logic                  w_in_init;
    logic                  w_in_run;
    logic                  w_in_replay;

    // Replay buffer: at most one pending read per port
    logic                  r_rp_lo_v;
    logic                  r_rp_hi_v;
    logic [AW-1:0]         r_rp_lo_addr;
    logic [AW-1:0]         r_rp_hi_addr;
    logic                  w_rp_lo_v_nxt;
    logic                  w_rp_hi_v_nxt;
    logic                  w_load_lo;
    logic                  w_load_hi;

    // Candidate accesses for this cycle, from the ports or from the buffer
    logic                  w_wr;
    logic                  w_lo_req;
    logic                  w_hi_req;
    logic [AW-1:0]         w_lo_addr;
    logic [AW-1:0]         w_hi_addr;
    logic [BW-1:0]         w_wr_bank;
    logic [BW-1:0]         w_lo_bank;
    logic [BW-1:0]         w_hi_bank;
    logic [RW-1:0]         w_wr_row;
    logic [RW-1:0]         w_lo_row;
    logic [RW-1:0]         w_hi_row;
    logic                  w_same_addr;
    logic                  w_lo_grant;
    logic                  w_hi_grant;

    // Read return path: bank select per port, per-bank read registers
    logic [BW-1:0]         r_lo_sel;
    logic [BW-1:0]         r_hi_sel;
    logic [DATA_WIDTH-1:0] w_bank_q [NUM_BANKS];

    assign w_in_init   = (r_state == C_ST_INIT);
    assign w_in_run    = (r_state == C_ST_RUN);
    assign w_in_replay = (r_state == C_ST_REPLAY);

    assign req_ready = w_in_run & ~freeze;
    assign init_done = ~w_in_init;

    // In REPLAY the buffered reads are the only traffic; no writes are accepted
    assign w_wr      = wr_valid & req_ready;
    assign w_lo_req  = w_in_replay ? (r_rp_lo_v & ~freeze) : (rd_lo_valid & req_ready);
    assign w_hi_req  = w_in_replay ? (r_rp_hi_v & ~freeze) : (rd_hi_valid & req_ready);
    assign w_lo_addr = w_in_replay ? r_rp_lo_addr : rd_lo_addr;
    assign w_hi_addr = w_in_replay ? r_rp_hi_addr : rd_hi_addr;

    assign w_wr_bank = wr_addr[BW-1:0];
    assign w_wr_row  = wr_addr[AW-1:BW];
    assign w_lo_bank = w_lo_addr[BW-1:0];
    assign w_lo_row  = w_lo_addr[AW-1:BW];
    assign w_hi_bank = w_hi_addr[BW-1:0];
    assign w_hi_row  = w_hi_addr[AW-1:BW];

    // Priority write > lo > hi per bank; lo and hi to the same word share one access
    assign w_same_addr = (w_lo_addr == w_hi_addr);
    assign w_lo_grant  = w_lo_req & ~(w_wr & (w_wr_bank == w_lo_bank));
    assign w_hi_grant  = w_hi_req
                       & ~(w_wr & (w_wr_bank == w_hi_bank))
                       & ~(w_lo_grant & (w_lo_bank == w_hi_bank) & ~w_same_addr);

    assign w_load_lo     = w_in_run & w_lo_req & ~w_lo_grant;
    assign w_load_hi     = w_in_run & w_hi_req & ~w_hi_grant;
    assign w_rp_lo_v_nxt = w_in_replay ? (r_rp_lo_v & ~w_lo_grant) : w_load_lo;
    assign w_rp_hi_v_nxt = w_in_replay ? (r_rp_hi_v & ~w_hi_grant) : w_load_hi;

    // Next-state logic for the INIT / RUN / REPLAY controller
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_INIT:   if (r_init_row == RW'(DEPTH - 1)) w_state_nxt = C_ST_RUN;
            C_ST_RUN:    if (w_rp_lo_v_nxt | w_rp_hi_v_nxt) w_state_nxt = C_ST_REPLAY;
            C_ST_REPLAY: if (~w_rp_lo_v_nxt & ~w_rp_hi_v_nxt) w_state_nxt = C_ST_RUN;
            default:     w_state_nxt = C_ST_INIT;
        endcase
    end

    // State register and INIT row sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= C_ST_INIT;
            r_init_row <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_in_init) r_init_row <= r_init_row + RW'(1);
        end
    end

    // Replay buffer capture of reads that lost arbitration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rp_lo_v    <= 1'b0;
            r_rp_hi_v    <= 1'b0;
            r_rp_lo_addr <= '0;
            r_rp_hi_addr <= '0;
        end else begin
            r_rp_lo_v <= w_rp_lo_v_nxt;
            r_rp_hi_v <= w_rp_hi_v_nxt;
            if (w_load_lo) r_rp_lo_addr <= rd_lo_addr;
            if (w_load_hi) r_rp_hi_addr <= rd_hi_addr;
        end
    end

    // Read result strobes and bank selects; frozen outputs keep their values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_lo_dvalid <= 1'b0;
            rd_hi_dvalid <= 1'b0;
            r_lo_sel     <= '0;
            r_hi_sel     <= '0;
        end else if (!freeze) begin
            rd_lo_dvalid <= w_lo_grant;
            rd_hi_dvalid <= w_hi_grant;
            if (w_lo_grant) r_lo_sel <= w_lo_bank;
            if (w_hi_grant) r_hi_sel <= w_hi_bank;
        end
    end

    // Bank read registers only load on a granted read, and no read is granted
    // under freeze, so the selected words stay stable while frozen.
    assign rd_lo_data = w_bank_q[r_lo_sel];
    assign rd_hi_data = w_bank_q[r_hi_sel];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam logic [BW-1:0] C_IDX = BW'(b);

        logic                  w_wr_hit;
        logic                  w_lo_hit;
        logic                  w_hi_hit;
        logic                  w_we;
        logic                  w_re;
        logic [RW-1:0]         w_row;
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_q;

        assign w_wr_hit = w_wr & (w_wr_bank == C_IDX);
        assign w_lo_hit = w_lo_grant & (w_lo_bank == C_IDX);
        assign w_hi_hit = w_hi_grant & (w_hi_bank == C_IDX);
        assign w_we     = w_in_init | w_wr_hit;
        assign w_re     = ~w_we & (w_lo_hit | w_hi_hit);
        assign w_row    = w_in_init ? r_init_row :
                          w_wr_hit  ? w_wr_row   :
                          w_lo_hit  ? w_lo_row   : w_hi_row;

        // Array write port: zero fill during INIT, otherwise the accepted write
        always_ff @(posedge clk) begin
            if (w_we) r_mem[w_row] <= w_in_init ? '0 : wr_data;
        end

        // Synchronous read register for this bank
        always_ff @(posedge clk or posedge rst) begin
            if (rst)       r_q <= '0;
            else if (w_re) r_q <= r_mem[w_row];
        end

        assign w_bank_q[b] = r_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bank_ctl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_bank_ctl
// Description : Self-checking bench for mem_bank_ctl. A word-addressed
//               reference model (flat array, pending-read slots, INIT cycle
//               count) predicts req_ready, read strobes, read data and
//               init_done every cycle under directed and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bank_ctl;

    localparam int NB  = 4;
    localparam int DW  = 39;
    localparam int DEP = 256;
    localparam int AWT = $clog2(NB) + $clog2(DEP);

    logic           clk = 1'b0;
    logic           rst;
    logic           freeze;
    logic           rd_lo_valid;
    logic [AWT-1:0] rd_lo_addr;
    logic           rd_hi_valid;
    logic [AWT-1:0] rd_hi_addr;
    logic           wr_valid;
    logic [AWT-1:0] wr_addr;
    logic [DW-1:0]  wr_data;
    logic           req_ready;
    logic [DW-1:0]  rd_lo_data;
    logic [DW-1:0]  rd_hi_data;
    logic           rd_lo_dvalid;
    logic           rd_hi_dvalid;
    logic           init_done;

    mem_bank_ctl #(
        .NUM_BANKS (NB),
        .DATA_WIDTH(DW),
        .DEPTH     (DEP)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .rd_lo_valid (rd_lo_valid),
        .rd_lo_addr  (rd_lo_addr),
        .rd_hi_valid (rd_hi_valid),
        .rd_hi_addr  (rd_hi_addr),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .req_ready   (req_ready),
        .rd_lo_data  (rd_lo_data),
        .rd_hi_data  (rd_hi_data),
        .rd_lo_dvalid(rd_lo_dvalid),
        .rd_hi_dvalid(rd_hi_dvalid),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            init_left;
    bit            pend_lo_v, pend_hi_v;
    logic [AWT-1:0] pend_lo_a, pend_hi_a;
    logic [DW-1:0] mem_m [1 << AWT];
    bit            e_lo_v, e_hi_v;
    logic [DW-1:0] e_lo_d, e_hi_d;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int bank_of(input logic [AWT-1:0] a);
        return int'(a) % NB;
    endfunction

    task automatic model_reset();
        init_left = DEP;
        pend_lo_v = 0;
        pend_hi_v = 0;
        e_lo_v    = 0;
        e_hi_v    = 0;
        e_lo_d    = '0;
        e_hi_d    = '0;
        for (int i = 0; i < (1 << AWT); i++) mem_m[i] = '0;
    endtask

    task automatic drive_idle();
        freeze      = 0;
        wr_valid    = 0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_lo_valid = 0;
        rd_lo_addr  = '0;
        rd_hi_valid = 0;
        rd_hi_addr  = '0;
    endtask

    // Called at a falling edge; asserts reset, checks the cleared outputs, releases.
    task automatic do_reset();
        rst = 1;
        drive_idle();
        #1;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_lo_dvalid", rd_lo_dvalid, 0);
        check_eq("rst_hi_dvalid", rd_hi_dvalid, 0);
        check_eq("rst_lo_data", rd_lo_data, 0);
        check_eq("rst_hi_data", rd_hi_data, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // One clock cycle: check registered outputs, drive inputs, check req_ready,
    // advance the model across the rising edge. Entered and left at a falling edge.
    task automatic cycle(input logic fr, input logic wv, input logic [AWT-1:0] wa,
                         input logic [DW-1:0] wd, input logic lv, input logic [AWT-1:0] la,
                         input logic hv, input logic [AWT-1:0] ha);
        bit go_lo, go_hi, exp_ready;
        check_eq("init_done", init_done, (init_left == 0));
        check_eq("lo_dvalid", rd_lo_dvalid, e_lo_v);
        check_eq("hi_dvalid", rd_hi_dvalid, e_hi_v);
        if (e_lo_v) check_eq("lo_data", rd_lo_data, e_lo_d);
        if (e_hi_v) check_eq("hi_data", rd_hi_data, e_hi_d);
        freeze = fr; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_lo_valid = lv; rd_lo_addr = la; rd_hi_valid = hv; rd_hi_addr = ha;
        #1;
        exp_ready = (init_left == 0) && !pend_lo_v && !pend_hi_v && !fr;
        check_eq("req_ready", req_ready, exp_ready);
        if (init_left > 0) begin
            init_left--;
            if (!fr) begin e_lo_v = 0; e_hi_v = 0; end
        end else if (pend_lo_v || pend_hi_v) begin
            if (!fr) begin
                go_lo = pend_lo_v;
                go_hi = pend_hi_v && !(pend_lo_v && bank_of(pend_lo_a) == bank_of(pend_hi_a)
                                       && pend_lo_a != pend_hi_a);
                e_lo_v = go_lo;
                e_hi_v = go_hi;
                if (go_lo) begin e_lo_d = mem_m[pend_lo_a]; pend_lo_v = 0; end
                if (go_hi) begin e_hi_d = mem_m[pend_hi_a]; pend_hi_v = 0; end
            end
        end else if (!fr) begin
            go_lo = lv && !(wv && bank_of(la) == bank_of(wa));
            go_hi = hv && !(wv && bank_of(ha) == bank_of(wa))
                       && !(go_lo && bank_of(la) == bank_of(ha) && la != ha);
            if (lv && !go_lo) begin pend_lo_v = 1; pend_lo_a = la; end
            if (hv && !go_hi) begin pend_hi_v = 1; pend_hi_a = ha; end
            e_lo_v = go_lo;
            e_hi_v = go_hi;
            if (go_lo) e_lo_d = mem_m[la];
            if (go_hi) e_hi_d = mem_m[ha];
            if (wv) mem_m[wa] = wd;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, '0, '0, 0, '0, 0, '0);
    endtask

    function automatic logic [AWT-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AWT'($urandom);
        return AWT'($urandom_range(0, 15));
    endfunction

    task automatic rnd_cycle(input int fr_pct);
        logic           fr, wv, lv, hv;
        logic [AWT-1:0] wa, la, ha;
        logic [DW-1:0]  wd;
        fr = ($urandom_range(0, 99) < fr_pct);
        wv = $urandom_range(0, 1) == 1;
        lv = $urandom_range(0, 2) != 0;
        hv = $urandom_range(0, 2) != 0;
        wa = rnd_addr();
        la = ($urandom_range(0, 4) == 0) ? wa : rnd_addr();
        ha = ($urandom_range(0, 4) == 0) ? la : rnd_addr();
        wd = DW'({$urandom, $urandom});
        cycle(fr, wv, wa, wd, lv, la, hv, ha);
    endtask

    initial begin
        rst = 1;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // INIT sweep with junk requests that must be ignored
        for (int i = 0; i < DEP; i++) rnd_cycle(20);
        idle(3);

        // Highest address reads zero after INIT
        cycle(0, 0, '0, '0, 1, AWT'(10'h3FF), 0, '0);
        idle(2);

        // Write then read on two banks in the following cycle
        cycle(0, 1, AWT'(10'h005), DW'(39'h12), 0, '0, 0, '0);
        cycle(0, 0, '0, '0, 1, AWT'(10'h005), 1, AWT'(10'h006));
        idle(2);

        // Write and read of the same address in one cycle
        cycle(0, 1, AWT'(10'h008), DW'(39'h7F), 1, AWT'(10'h008), 0, '0);
        idle(3);

        // Three-way conflict on bank 0
        cycle(0, 1, AWT'(10'h004), DW'(39'h4A), 1, AWT'(10'h008), 1, AWT'(10'h00C));
        idle(4);

        // Merged read of one word on both ports
        cycle(0, 0, '0, '0, 1, AWT'(10'h005), 1, AWT'(10'h005));
        idle(2);

        // Freeze for three cycles while a read result is valid
        cycle(0, 1, AWT'(10'h009), DW'(39'h55), 0, '0, 0, '0);
        cycle(0, 0, '0, '0, 1, AWT'(10'h009), 0, '0);
        repeat (3) rnd_cycle(100);
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) rnd_cycle(15);
        idle(4);

        // Reset while in REPLAY discards buffered reads
        cycle(0, 1, AWT'(10'h004), DW'(39'h1), 1, AWT'(10'h008), 1, AWT'(10'h00C));
        do_reset();
        for (int i = 0; i < DEP + 4; i++) rnd_cycle(20);

        // Reset at INIT row 100 restarts the full sweep
        do_reset();
        for (int i = 0; i < 100; i++) rnd_cycle(10);
        do_reset();
        for (int i = 0; i < DEP + 2; i++) rnd_cycle(10);

        for (int i = 0; i < 800; i++) rnd_cycle(15);
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bank_ctl.md
MEM_BANK_CTL -- requirements
Module: mem_bank_ctl

Interface
REQ-001: Parameter NUM_BANKS, default 4, number of single-ported banks; legal values 2, 4, 8.
REQ-002: Parameter DATA_WIDTH, default 39, bits per word (data plus ECC, stored opaquely).
REQ-003: Parameter DEPTH, default 256, rows per bank; power of two, at least 4.
REQ-004: Derived localparams: BW = log2(NUM_BANKS), RW = log2(DEPTH), AW = BW+RW.
REQ-005: clk  input  1  sole clock; all state on rising edge.
REQ-006: rst  input  1  reset; asynchronous, active-high.
REQ-007: freeze  input  1  hold read outputs and block acceptance (pipeline freeze).
REQ-008: rd_lo_valid, rd_hi_valid  input  1 each  read requests, lo and hi port.
REQ-009: rd_lo_addr, rd_hi_addr  input  AW each  word addresses; bank = addr[BW-1:0], row = addr[AW-1:BW].
REQ-010: wr_valid  input  1  write request.
REQ-011: wr_addr  input  AW  write word address.
REQ-012: wr_data  input  DATA_WIDTH  write word.
REQ-013: req_ready  output  1  all requests presented this cycle are accepted when high.
REQ-014: rd_lo_data, rd_hi_data  output  DATA_WIDTH each  read results.
REQ-015: rd_lo_dvalid, rd_hi_dvalid  output  1 each  read result valid strobes.
REQ-016: init_done  output  1  memory zero-initialisation complete.

Function
REQ-017: Control FSM SHALL have states INIT, RUN, REPLAY.
- INIT: one row counter writes zero to that row in every bank per cycle, DEPTH cycles; at count DEPTH-1 go to RUN, init_done=1 thereafter.
REQ-018: In INIT, req_ready SHALL be 0 and all requests SHALL be ignored.
REQ-019: In RUN, req_ready = ~freeze; a request is accepted when valid and req_ready are both 1.
REQ-020: Each bank SHALL perform at most one access per cycle; priority write > rd_lo > rd_hi.
REQ-021: rd_lo and rd_hi to the same bank and same row SHALL be merged into one access; both ports return the word.
REQ-022: Accepted requests losing bank arbitration SHALL be captured in a replay buffer (max one rd_lo, one rd_hi); FSM goes to REPLAY next cycle.
REQ-023: REPLAY issues buffered reads, rd_lo before rd_hi when they still conflict (up to 2 cycles); req_ready=0 throughout; return to RUN when the buffer is empty.
REQ-024: Read latency SHALL be exactly 1 cycle from issue (acceptance or replay); dvalid pulses for one cycle except under freeze.
REQ-025: Write and read to the same address in one cycle: write wins, read replays and returns the new data.
REQ-026: While freeze=1, rd_*_data and rd_*_dvalid SHALL hold their values; replay issue and any read data capture SHALL stall; INIT SHALL proceed unaffected.
REQ-027: Writes have no response; data is visible to any read issued on a later cycle.
REQ-028: Address bits are used modulo AW; no out-of-range check.

Reset
REQ-029: On rst assertion, asynchronously: FSM=INIT, row counter=0, replay buffer empty, req_ready=0, init_done=0, rd_*_dvalid=0, rd_*_data=0.
REQ-030: rst asserted mid-INIT or mid-REPLAY SHALL restart INIT from row 0 and discard buffered requests.
REQ-031: Array contents are not reset directly; INIT establishes all-zero.

Verification
REQ-032: Release rst, defaults -> init_done rises 256 cycles later; read addr 0x3FF -> rd_lo_data=0, rd_lo_dvalid 1 cycle after acceptance.
REQ-033: Write 0x12 to addr 0x005, next cycle rd_lo addr 0x005 and rd_hi addr 0x006 -> both dvalid next cycle, data 0x12 and 0, req_ready stays 1.
REQ-034: Same cycle wr addr 0x008 data 0x7F, rd_lo addr 0x008 -> req_ready 0 next cycle, rd_lo_dvalid 2 cycles after acceptance with 0x7F.
REQ-035: wr 0x004, rd_lo 0x008, rd_hi 0x00C (all bank 0) -> rd_lo data 2 cycles later, rd_hi 3 cycles later, req_ready low 2 cycles.
REQ-036: freeze held 3 cycles while rd_lo_dvalid=1 with data 0x55 -> outputs hold 0x55/1, no acceptance, resume on release.
REQ-037: Assert rst at INIT row 100 -> init_done stays 0, full 256-cycle INIT repeats; repeat with NUM_BANKS=8, DEPTH=16 -> 16 cycles.
